// File: rtl/alut_age_checker14.sv
// Age sweeper for the address lookup table: walks every entry, invalidates stale ones.
// Optional feature: define ALUT_AGE_STATS_EN to keep a count of entries invalidated per sweep.
module alut_age_checker14 #(
  parameter int DW = 83,
  parameter int DD = 256
) (
  input  logic          pclk14,
  input  logic          n_p_reset14,
  input  logic          check_age14,
  input  logic [31:0]   max_age14,
  input  logic [31:0]   curr_time14,
  input  logic          add_lock14,
  input  logic [DW-1:0] mem_read_data_age14,
  output logic [7:0]    mem_addr_age14,
  output logic          mem_write_age14,
  output logic [DW-1:0] mem_write_data_age14,
  output logic          age_busy14,
  output logic          age_done14,
  output logic [8:0]    aged_count14
);

  typedef enum logic [2:0] {IDLE, RD, CHK, WR, DONE} state_t;

  localparam logic [7:0] LAST_ADDR = 8'(DD - 1);

  state_t        state, state_nxt;
  logic [7:0]    addr_q, addr_nxt;
  logic [DW-1:0] wdata_q, wdata_nxt;
  logic [31:0]   age;
  logic          stale;
  logic          last;

  // Unsigned modular subtraction keeps the age correct across timestamp wrap.
  assign age   = curr_time14 - mem_read_data_age14[31:0];
  assign stale = mem_read_data_age14[DW-1] && (age > max_age14);
  assign last  = (addr_q == LAST_ADDR);

  always_ff @(posedge pclk14 or negedge n_p_reset14) begin
    if (!n_p_reset14) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    case (state)
      IDLE: begin
        if (check_age14) begin
          state_nxt = RD;
          addr_nxt  = '0;
        end
      end
      RD: begin
        if (!add_lock14) state_nxt = CHK;
      end
      CHK: begin
        if (stale) begin
          state_nxt            = WR;
          wdata_nxt            = mem_read_data_age14;
          wdata_nxt[DW-1]      = 1'b0;
        end else if (last) begin
          state_nxt = DONE;
        end else begin
          state_nxt = RD;
          addr_nxt  = addr_q + 8'd1;
        end
      end
      WR: begin
        if (!add_lock14) begin
          if (last) begin
            state_nxt = DONE;
          end else begin
            state_nxt = RD;
            addr_nxt  = addr_q + 8'd1;
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset clears them immediately.
  assign mem_addr_age14       = addr_q;
  assign mem_write_age14      = (state == WR) && !add_lock14;
  assign mem_write_data_age14 = wdata_q;
  assign age_busy14           = (state == RD) || (state == CHK) || (state == WR);
  assign age_done14           = (state == DONE);

`ifdef ALUT_AGE_STATS_EN
  logic [8:0] aged_cnt_q;

  always_ff @(posedge pclk14 or negedge n_p_reset14) begin
    if (!n_p_reset14) begin
      aged_cnt_q <= '0;
    end else if ((state == IDLE) && check_age14) begin
      aged_cnt_q <= '0;
    end else if (mem_write_age14) begin
      aged_cnt_q <= aged_cnt_q + 9'd1;
    end
  end

  assign aged_count14 = aged_cnt_q;
`else
  assign aged_count14 = '0;
`endif

endmodule

// File: tb/tb_alut_age_checker14.sv
// Randomized bench for alut_age_checker14 with an array-level reference of one full sweep.
module tb_alut_age_checker14;

  localparam int DW  = 83;
  localparam int DD  = 256;
  localparam int TMO = 4000;

`ifdef ALUT_AGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          pclk14 = 1'b0;
  logic          n_p_reset14 = 1'b0;
  logic          check_age14 = 1'b0;
  logic [31:0]   max_age14 = '0;
  logic [31:0]   curr_time14 = '0;
  logic          add_lock14 = 1'b0;
  logic [DW-1:0] mem_read_data_age14;
  logic [7:0]    mem_addr_age14;
  logic          mem_write_age14;
  logic [DW-1:0] mem_write_data_age14;
  logic          age_busy14;
  logic          age_done14;
  logic [8:0]    aged_count14;

  alut_age_checker14 #(.DW(DW), .DD(DD)) dut (
    .pclk14               (pclk14),
    .n_p_reset14          (n_p_reset14),
    .check_age14          (check_age14),
    .max_age14            (max_age14),
    .curr_time14          (curr_time14),
    .add_lock14           (add_lock14),
    .mem_read_data_age14  (mem_read_data_age14),
    .mem_addr_age14       (mem_addr_age14),
    .mem_write_age14      (mem_write_age14),
    .mem_write_data_age14 (mem_write_data_age14),
    .age_busy14           (age_busy14),
    .age_done14           (age_done14),
    .aged_count14         (aged_count14)
  );

  always #5 pclk14 = ~pclk14;

  typedef struct packed {
    logic [7:0]    a;
    logic [DW-1:0] d;
  } wr_t;

  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic          do_load = 1'b0;
  logic [DW-1:0] init_mem [DD];
  logic [DW-1:0] mem      [DD];
  logic [DW-1:0] ref_mem  [DD];
  wr_t           wr_q[$];
  wr_t           exp_q[$];
  int            lock_viol = 0;
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            nst = 0;
  int            sc = 0;

  // Memory with one-cycle registered read; bulk load is a bench backdoor.
  always @(posedge pclk14) begin
    cyc <= cyc + 1;
    mem_read_data_age14 <= mem[mem_addr_age14];
    if (do_load) begin
      for (int i = 0; i < DD; i++) mem[i] <= init_mem[i];
    end else if (mem_write_age14) begin
      mem[mem_addr_age14] <= mem_write_data_age14;
    end
  end

  always @(negedge pclk14) begin
    #1;
    if (mem_write_age14) wr_q.push_back('{a: mem_addr_age14, d: mem_write_data_age14});
    if (mem_write_age14 && add_lock14) lock_viol++;
    if (age_done14) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic make_entry(input bit v, input logic [31:0] ts, output logic [DW-1:0] e);
    e = {v, 16'($urandom), $urandom, 2'($urandom), ts};
  endtask

  task automatic clear_init();
    for (int i = 0; i < DD; i++) init_mem[i] = '0;
  endtask

  task automatic load_mem();
    do_load = 1'b1;
    @(negedge pclk14);
    do_load = 1'b0;
    @(negedge pclk14);
  endtask

  task automatic rand_fill(output logic [31:0] ct, output logic [31:0] mx);
    logic [31:0] age;
    ct = $urandom;
    mx = $urandom_range(0, 1000);
    for (int i = 0; i < DD; i++) begin
      case ($urandom_range(0, 2))
        0:       age = mx;
        1:       age = mx + 32'd1;
        default: age = $urandom_range(0, 2000);
      endcase
      make_entry(1'($urandom_range(0, 1)), ct - age, init_mem[i]);
    end
    load_mem();
  endtask

  // Expected outcome of one sweep: every valid entry older than the threshold loses its valid bit, in address order.
  task automatic build_ref(input logic [31:0] ct, input logic [31:0] mx);
    logic [31:0] age;
    nst = 0;
    exp_q.delete();
    for (int i = 0; i < DD; i++) begin
      ref_mem[i] = mem[i];
      age = ct - mem[i][31:0];
      if (mem[i][DW-1] && (age > mx)) begin
        ref_mem[i][DW-1] = 1'b0;
        exp_q.push_back('{a: 8'(i), d: ref_mem[i]});
        nst++;
      end
    end
  endtask

  task automatic start_sweep(input logic [31:0] ct, input logic [31:0] mx);
    curr_time14 = ct;
    max_age14   = mx;
    build_ref(ct, mx);
    wr_q.delete();
    done_cnt  = 0;
    lock_viol = 0;
    check_age14 = 1'b1;
    @(negedge pclk14);
    check_age14 = 1'b0;
    sc = cyc;
    chk("start_busy", age_busy14, 1'b1);
    chk("start_addr", mem_addr_age14, 8'd0);
    chk("start_count_clr", aged_count14, 9'd0);
    chk("start_no_wr", mem_write_age14, 1'b0);
  endtask

  task automatic wait_addr(input logic [7:0] a);
    int g = 0;
    while (mem_addr_age14 !== a && g < TMO) begin
      @(negedge pclk14);
      g++;
    end
    chk("wait_addr", mem_addr_age14, a);
  endtask

  task automatic finish_sweep(input bit rnd, input bit timed);
    int g = 0;
    int bad = 0;
    while (!age_done14 && g < TMO) begin
      if (rnd) begin
        add_lock14  = ($urandom_range(0, 3) == 0);
        check_age14 = 1'($urandom_range(0, 1));
      end
      @(negedge pclk14);
      g++;
    end
    chk("done_seen", age_done14, 1'b1);
    add_lock14  = 1'b0;
    check_age14 = 1'b1;
    @(negedge pclk14);
    check_age14 = 1'b0;
    chk("done_one_cycle", age_done14, 1'b0);
    chk("idle_after_done", age_busy14, 1'b0);
    repeat (3) @(negedge pclk14);
    chk("no_restart", age_busy14, 1'b0);
    chk("done_count", done_cnt, 1);
    if (timed) chk("done_latency", done_cyc - sc, 2 * DD + nst);
    chk("wr_count", wr_q.size(), exp_q.size());
    for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
      chk("wr_addr", wr_q[i].a, exp_q[i].a);
      chk("wr_data", wr_q[i].d, exp_q[i].d);
    end
    for (int i = 0; i < DD; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", bad, 0);
    chk("no_wr_locked", lock_viol, 0);
    chk("aged_count", aged_count14, STATS ? nst : 0);
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_addr"}, mem_addr_age14, 8'd0);
    chk({pfx, "_wr"}, mem_write_age14, 1'b0);
    chk({pfx, "_wdata"}, mem_write_data_age14, '0);
    chk({pfx, "_busy"}, age_busy14, 1'b0);
    chk({pfx, "_done"}, age_done14, 1'b0);
    chk({pfx, "_count"}, aged_count14, 9'd0);
  endtask

  initial begin
    logic [31:0] ct, mx;
    clear_init();
    @(negedge pclk14);
    load_mem();
    chk_zero_outputs("reset");
    n_p_reset14 = 1'b1;
    @(negedge pclk14);

    // All entries invalid: read-only sweep, fixed latency.
    start_sweep(32'h0000_1000, 32'd0);
    finish_sweep(1'b0, 1'b1);

    // Single stale entry at address 5.
    clear_init();
    make_entry(1'b1, 32'd100, init_mem[5]);
    load_mem();
    start_sweep(32'd300, 32'd150);
    finish_sweep(1'b0, 1'b1);

    // Age equal to threshold is kept.
    clear_init();
    make_entry(1'b1, 32'd100, init_mem[9]);
    load_mem();
    start_sweep(32'd250, 32'd150);
    finish_sweep(1'b0, 1'b1);

    // Timestamp wrap: age 0x20 beats threshold 0x10.
    clear_init();
    make_entry(1'b1, 32'hFFFF_FFF0, init_mem[3]);
    load_mem();
    start_sweep(32'h10, 32'h10);
    finish_sweep(1'b0, 1'b1);

    // Lock held in RD at address 7, then in WR at address 20.
    clear_init();
    make_entry(1'b1, 32'd0, init_mem[20]);
    load_mem();
    start_sweep(32'd1000, 32'd10);
    wait_addr(8'd7);
    add_lock14 = 1'b1;
    repeat (10) @(negedge pclk14);
    chk("lock_rd_addr", mem_addr_age14, 8'd7);
    chk("lock_rd_busy", age_busy14, 1'b1);
    add_lock14 = 1'b0;
    wait_addr(8'd20);
    @(negedge pclk14);
    add_lock14 = 1'b1;
    repeat (10) @(negedge pclk14);
    chk("lock_wr_addr", mem_addr_age14, 8'd20);
    chk("lock_wr_strobe", mem_write_age14, 1'b0);
    chk("lock_wr_pending", wr_q.size(), 0);
    add_lock14 = 1'b0;
    finish_sweep(1'b0, 1'b0);

    // Asynchronous reset in the middle of a sweep.
    rand_fill(ct, mx);
    start_sweep(ct, mx);
    wait_addr(8'd100);
    #2;
    n_p_reset14 = 1'b0;
    #1;
    chk_zero_outputs("midreset");
    done_cnt = 0;
    wr_q.delete();
    repeat (2) @(negedge pclk14);
    n_p_reset14 = 1'b1;
    repeat (10) @(negedge pclk14);
    chk("post_reset_done", done_cnt, 0);
    chk("post_reset_wr", wr_q.size(), 0);
    chk("post_reset_busy", age_busy14, 1'b0);
    start_sweep(ct, mx);
    finish_sweep(1'b0, 1'b1);

    // Random tables, alternating clean and disturbed (lock / spurious start) sweeps.
    for (int k = 0; k < 6; k++) begin
      rand_fill(ct, mx);
      start_sweep(ct, mx);
      finish_sweep(k[0], !k[0]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alut_age_checker14.md
ALUT_AGE_CHECKER14 -- requirements
Module: alut_age_checker14

Interface
REQ-001 Parameter DW, default 83, SHALL be the entry width; the layout is [82] valid, [81:34] MAC, [33:32] port, [31:0] timestamp.
REQ-002 Parameter DD, default 256, SHALL be the number of entries swept; addresses run 0..DD-1.
REQ-003 pclk14  in  1  single clock; all state changes on its rising edge.
REQ-004 n_p_reset14  in  1  asynchronous active-low reset.
REQ-005 check_age14  in  1  one-cycle sweep start request.
REQ-006 max_age14  in  32  age threshold in timestamp ticks.
REQ-007 curr_time14  in  32  free-running timestamp from the address checker.
REQ-008 add_lock14  in  1  address checker owns the array this cycle; the sweep SHALL stall.
REQ-009 mem_read_data_age14  in  DW  registered read data from the memory age port.
REQ-010 mem_addr_age14  out  8  age-port address.
REQ-011 mem_write_age14  out  1  age-port write strobe (1 = write, 0 = read).
REQ-012 mem_write_data_age14  out  DW  age-port write data.
REQ-013 age_busy14  out  1  sweep in progress.
REQ-014 age_done14  out  1  one-cycle pulse at sweep completion.
REQ-015 aged_count14  out  9  number of entries invalidated in the last sweep.

Function
REQ-016 The FSM SHALL have the states IDLE, RD, CHK, WR and DONE.
REQ-017 IDLE: when check_age14=1, the FSM SHALL go to RD with address 0 and age_busy14=1 from the next cycle; aged_count14 SHALL clear to 0.
REQ-018 RD: the block SHALL drive mem_write_age14=0 with the current address; if add_lock14=1 it SHALL stay in RD, otherwise it SHALL go to CHK.
REQ-019 CHK: mem_read_data_age14 is valid here (one-cycle memory latency); mem_write_age14 SHALL be 0.
REQ-020 Age SHALL be (curr_time14 - entry[31:0]) mod 2^32, so timestamp wrap-around yields the correct age.
REQ-021 An entry SHALL be stale iff valid=1 and age > max_age14 (strictly greater; age equal to max_age14 is not stale).
REQ-022 CHK with a stale entry SHALL go to WR; otherwise it SHALL go to RD at address+1, or to DONE if the address is DD-1.
REQ-023 WR: if add_lock14=1 the block SHALL hold WR with mem_write_age14=0.
REQ-024 WR with add_lock14=0: the block SHALL drive for one cycle mem_write_age14=1 and mem_write_data_age14 = the CHK data with bit 82 cleared (other bits unchanged), then increment aged_count14 and advance as in REQ-022.
REQ-025 DONE: the block SHALL pulse age_done14=1 for one cycle, set age_busy14=0 and go to IDLE.
REQ-026 check_age14 while busy, or in the DONE cycle, SHALL be ignored.
REQ-027 mem_write_age14 SHALL never be 1 outside WR.
REQ-028 The address SHALL not wrap within a sweep.
REQ-029 aged_count14 SHALL hold its value until the next accepted start; its maximum is 256.

Reset
REQ-030 While n_p_reset14=0: state=IDLE, mem_addr_age14=0, mem_write_age14=0, mem_write_data_age14=0, age_busy14=0, age_done14=0, aged_count14=0.
REQ-031 Reset mid-sweep SHALL abort the sweep immediately with no further writes, and no done pulse after release.

Configuration
REQ-032 With ALUT_AGE_STATS_EN defined, aged_count14 SHALL behave as in REQ-017, REQ-024 and REQ-029.
REQ-033 Without ALUT_AGE_STATS_EN, aged_count14 SHALL be constant 0, no counter register SHALL exist, and all other behaviour SHALL be identical.

Verification
REQ-034 Scenario: all entries invalid, check_age14 pulse, add_lock14=0 -> 256 reads, no writes, age_done14 exactly 512 cycles after start+1, aged_count14=0.
REQ-035 Scenario: entry 5 valid, ts=100, curr_time14=300, max_age14=150 -> one write at address 5 with bit 82=0 and other bits unchanged; aged_count14=1.
REQ-036 Scenario: age equal to threshold (ts=100, curr=250, max=150) -> no write. Wrap case (ts=0xFFFFFFF0, curr=0x10, max=0x10) -> age 0x20, entry invalidated.
REQ-037 Scenario: add_lock14 held for 10 cycles during RD at address 7, and separately during WR -> address held, mem_write_age14 stays 0 while locked, sweep resumes correctly afterwards.
REQ-038 Scenario: n_p_reset14 asserted mid-sweep at address 100 -> all outputs 0 asynchronously; a new check_age14 after release starts at address 0.
REQ-039 Scenario: build without ALUT_AGE_STATS_EN, repeat REQ-035 -> same memory write, aged_count14=0.
